// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter_bank block.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
//
// mode_e     : per-channel boundary behaviour (wrap around or saturate).
// chan_cfg_t : one configuration write (modulus + mode). The limit field is
//              sized for the widest supported channel (Width <= 31); each
//              channel validates the full field and keeps only Width+1 bits.
// limit_ok   : a modulus is legal when 1 <= limit <= 2**width.
package counter_bank_pkg;

    typedef enum logic {
        ModeWrap = 1'b0,
        ModeSat  = 1'b1
    } mode_e;

    localparam int CfgLimitW = 32;

    typedef struct packed {
        logic [CfgLimitW-1:0] limit;
        mode_e                mode;
    } chan_cfg_t;

    function automatic logic limit_ok(input logic [CfgLimitW-1:0] limit,
                                      input int unsigned          width);
        return (limit != '0) && ({32'd0, limit} <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/counter_channel.sv
// Single modulo counter: runtime limit/mode, registered value, event pulse, sticky flag.
// Latency: request in cycle n updates value_o/wrap_o at the edge ending n; will_wrap_o is combinational.
// Backpressure: none; every request is accepted every cycle.
//
// Ports: clk_i, rst_i (sync, active-high); inc_i/dec_i/clr_i requests;
// cfg_we_i + cfg_i configuration write; sticky_clr_i; value_o, will_wrap_o,
// wrap_o, sticky_o. Optional feature macro: COUNTER_BANK_STICKY_EN.
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int Width        = 8,
    parameter int DefaultLimit = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    input  logic             cfg_we_i,
    input  chan_cfg_t        cfg_i,
    input  logic             sticky_clr_i,
    output logic [Width-1:0] value_o,
    output logic             will_wrap_o,
    output logic             wrap_o,
    output logic             sticky_o
);

    localparam int LimitW = Width + 1;

    logic [LimitW-1:0] limit_q;
    mode_e             mode_q;
    logic [Width-1:0]  value_q;
    logic [Width-1:0]  value_d;
    logic              wrap_q;

    logic              cfg_ok;
    logic              step_up;
    logic              step_dn;
    logic              at_top;
    logic              at_zero;
    logic              evt;
    logic [LimitW-1:0] top;

    // An illegal modulus discards the whole write, so the requests of that
    // cycle proceed as if no write happened.
    assign cfg_ok  = cfg_we_i && limit_ok(cfg_i.limit, Width);

    // Limit compare runs in Width+1 bits so M = 2**Width needs no overflow case.
    assign top     = limit_q - LimitW'(1);
    assign at_top  = ({1'b0, value_q} == top);
    assign at_zero = (value_q == '0);

    // inc & dec together cancel; clr and a valid config write override both.
    assign step_up = inc_i && !dec_i && !clr_i && !cfg_ok;
    assign step_dn = dec_i && !inc_i && !clr_i && !cfg_ok;

    // A step into a boundary is an event in both modes (wrap or blocked).
    assign evt         = (step_up && at_top) || (step_dn && at_zero);
    assign will_wrap_o = evt;

    always_comb begin
        value_d = value_q;
        if (cfg_ok || clr_i) begin
            value_d = '0;
        end else if (step_up) begin
            if (!at_top) begin
                value_d = value_q + Width'(1);
            end else if (mode_q == ModeWrap) begin
                value_d = '0;
            end
        end else if (step_dn) begin
            if (!at_zero) begin
                value_d = value_q - Width'(1);
            end else if (mode_q == ModeWrap) begin
                value_d = top[Width-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            limit_q <= LimitW'(DefaultLimit);
            mode_q  <= ModeWrap;
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= evt;
            if (cfg_ok) begin
                limit_q <= cfg_i.limit[LimitW-1:0];
                mode_q  <= cfg_i.mode;
            end
        end
    end

    assign value_o = value_q;
    assign wrap_o  = wrap_q;

`ifdef COUNTER_BANK_STICKY_EN
    logic sticky_q;

    // Set wins over a same-cycle clear so no event is ever lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (evt) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr_i) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_o = sticky_q;
`else
    logic sticky_clr_unused;

    assign sticky_clr_unused = sticky_clr_i;
    assign sticky_o          = 1'b0;
`endif

endmodule

// File: rtl/counter_bank.sv
// Bank of NumChannels independent modulo counters sharing one configuration port.
// Latency: value_o/wrap_o/sticky_o registered (1 cycle); will_wrap_o combinational.
// Backpressure: none; requests and config writes are accepted every cycle.
//
// Ports: clk_i, rst_i (sync, active-high); inc_i/dec_i/clr_i/sticky_clr_i per
// channel; cfg_we_i/cfg_sel_i/cfg_limit_i/cfg_mode_i shared config write;
// value_o (channel k at [k*Width +: Width]), will_wrap_o, wrap_o, sticky_o.
// Optional feature macro: COUNTER_BANK_STICKY_EN (sticky flags; tied 0 otherwise).
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter  int NumChannels  = 4,
    parameter  int Width        = 8,
    parameter  int DefaultLimit = 16,
    localparam int SelW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumChannels-1:0]       inc_i,
    input  logic [NumChannels-1:0]       dec_i,
    input  logic [NumChannels-1:0]       clr_i,
    input  logic                         cfg_we_i,
    input  logic [SelW-1:0]              cfg_sel_i,
    input  logic [Width:0]               cfg_limit_i,
    input  mode_e                        cfg_mode_i,
    input  logic [NumChannels-1:0]       sticky_clr_i,
    output logic [NumChannels*Width-1:0] value_o,
    output logic [NumChannels-1:0]       will_wrap_o,
    output logic [NumChannels-1:0]       wrap_o,
    output logic [NumChannels-1:0]       sticky_o
);

    chan_cfg_t cfg;

    assign cfg.limit = CfgLimitW'(cfg_limit_i);
    assign cfg.mode  = cfg_mode_i;

    for (genvar k = 0; k < NumChannels; k++) begin : g_chan
        logic cfg_hit;

        // A select beyond the last channel matches no channel and is dropped.
        assign cfg_hit = cfg_we_i && (cfg_sel_i == SelW'(k));

        counter_channel #(
            .Width        (Width),
            .DefaultLimit (DefaultLimit)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .inc_i        (inc_i[k]),
            .dec_i        (dec_i[k]),
            .clr_i        (clr_i[k]),
            .cfg_we_i     (cfg_hit),
            .cfg_i        (cfg),
            .sticky_clr_i (sticky_clr_i[k]),
            .value_o      (value_o[k*Width +: Width]),
            .will_wrap_o  (will_wrap_o[k]),
            .wrap_o       (wrap_o[k]),
            .sticky_o     (sticky_o[k])
        );
    end

endmodule
